// File: rtl/gcm_ctr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : gcm_ctr_gen
//  Purpose  : GCM counter-block generator; emits a burst of counter blocks
//             with a modulo-2^INC_W low-field increment and valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module gcm_ctr_gen #(
   parameter int BLOCK_W = 128,
   parameter int INC_W   = 32,
   parameter int LEN_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BLOCK_W-1:0] iv_in,
   input  logic [LEN_W-1:0]   num_blocks,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_block,
   output logic [LEN_W-1:0]   out_idx,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [BLOCK_W-1:0] r_block;
   logic [LEN_W-1:0]   r_idx;
   logic [LEN_W-1:0]   r_num;
   logic               r_valid;
   logic               r_busy;
   logic               r_done;
   logic               r_wrap;

   logic [BLOCK_W-1:0] w_next_block;
   logic               w_hs;
   logic               w_low_ones;
   logic               w_last;

   assign w_hs       = r_valid & out_ready;
   assign w_low_ones = &r_block[INC_W-1:0];
   assign w_last     = (r_idx == r_num - LEN_W'(1));

   // Upper bits never see a carry out of the low field.
   generate
      if (INC_W >= BLOCK_W) begin : g_full
         assign w_next_block = r_block + BLOCK_W'(1);
      end else begin : g_part
         assign w_next_block = {r_block[BLOCK_W-1:INC_W],
                                r_block[INC_W-1:0] + INC_W'(1)};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_block <= '0;
         r_idx   <= '0;
         r_num   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start && !abort) begin
                  r_block <= iv_in;
                  r_num   <= num_blocks;
                  r_idx   <= '0;
                  r_wrap  <= 1'b0;
                  r_busy  <= 1'b1;
                  if (num_blocks != '0) begin
                     r_state <= S_RUN;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               // A handshake taken in the abort cycle still advances the counter.
               if (w_hs) begin
                  r_block <= w_next_block;
                  r_idx   <= r_idx + LEN_W'(1);
                  if (w_low_ones) r_wrap <= 1'b1;
               end
               if (abort) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (w_hs && w_last) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_block = r_block;
   assign out_idx   = r_idx;
   assign busy      = r_busy;
   assign done      = r_done;
   assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gcm_ctr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcm_ctr_gen
//  Purpose  : Directed table-driven bench for gcm_ctr_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcm_ctr_gen;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] iv_in;
   logic [15:0]  num_blocks;
   logic         abort;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic [15:0]  out_idx;
   logic         busy;
   logic         done;
   logic         wrap;

   int checks = 0;
   int errors = 0;

   gcm_ctr_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .iv_in      (iv_in),
      .num_blocks (num_blocks),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_block  (out_block),
      .out_idx    (out_idx),
      .busy       (busy),
      .done       (done),
      .wrap       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] iv;
      logic [15:0]  num;
      logic [127:0] last;
      logic         exp_wrap;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int i);
      logic [31:0] lo;
      iv_in      = vecs[i].iv;
      num_blocks = vecs[i].num;
      out_ready  = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < int'(vecs[i].num); k++) begin
         lo = vecs[i].iv[31:0] + 32'(k);
         chk($sformatf("v%0d_valid%0d", i, k), 128'(out_valid), 128'(1));
         chk($sformatf("v%0d_block%0d", i, k), out_block, {vecs[i].iv[127:32], lo});
         chk($sformatf("v%0d_idx%0d", i, k), 128'(out_idx), 128'(k));
         if (k == int'(vecs[i].num) - 1)
            chk($sformatf("v%0d_last", i), out_block, vecs[i].last);
         tick();
      end
      chk($sformatf("v%0d_done_valid", i), 128'(out_valid), 128'(0));
      chk($sformatf("v%0d_done", i), 128'(done), 128'(1));
      chk($sformatf("v%0d_done_busy", i), 128'(busy), 128'(1));
      chk($sformatf("v%0d_wrap", i), 128'(wrap), 128'(vecs[i].exp_wrap));
      tick();
      chk($sformatf("v%0d_idle_done", i), 128'(done), 128'(0));
      chk($sformatf("v%0d_idle_busy", i), 128'(busy), 128'(0));
   endtask

   initial begin
      int  hs;
      bit  seen_done;
      logic [127:0] held;

      vecs[0] = '{{96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFFFFFE}, 16'd3,
                  {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h00000000}, 1'b1};
      vecs[1] = '{128'h01234567_89ABCDEF_00112233_44556677, 16'd2,
                  128'h01234567_89ABCDEF_00112233_44556678, 1'b0};
      vecs[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'd2,
                  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000, 1'b1};
      vecs[3] = '{128'h0, 16'd1, 128'h0, 1'b0};
      vecs[4] = '{{96'h1, 32'h7FFFFFFF}, 16'd2, {96'h1, 32'h80000000}, 1'b0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      iv_in = '0; num_blocks = '0;
      #3;
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_wrap", 128'(wrap), 128'(0));
      chk("rst_block", out_block, 128'(0));
      chk("rst_idx", 128'(out_idx), 128'(0));

      // Zero-length burst, accepted on the first edge after reset release.
      #9;
      rst_n = 1'b1; start = 1'b1; iv_in = 128'hDEAD; num_blocks = 16'd0;
      tick();
      start = 1'b0;
      chk("zero_valid", 128'(out_valid), 128'(0));
      chk("zero_busy", 128'(busy), 128'(1));
      chk("zero_done", 128'(done), 128'(1));
      tick();
      chk("zero_idle_busy", 128'(busy), 128'(0));
      chk("zero_idle_done", 128'(done), 128'(0));
      chk("zero_idle_valid", 128'(out_valid), 128'(0));

      for (int i = 0; i < 5; i++) run_vec(i);

      // Back-pressure: hold for 5 cycles at out_idx 1.
      iv_in = 128'h11112222_33334444_55556666_77778888; num_blocks = 16'd4;
      out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      hs = 1;
      tick();
      out_ready = 1'b0;
      held = out_block;
      chk("stall_idx_entry", 128'(out_idx), 128'(1));
      chk("stall_block_entry", held, 128'h11112222_33334444_55556666_77778889);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("stall_hold_block%0d", c), out_block, 128'h11112222_33334444_55556666_77778889);
         chk($sformatf("stall_hold_idx%0d", c), 128'(out_idx), 128'(1));
      end
      out_ready = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         if (out_valid && out_ready) hs++;
         tick();
         if (done) seen_done = 1'b1;
      end
      chk("stall_done_seen", 128'(seen_done), 128'(1));
      chk("stall_handshakes", 128'(hs), 128'(4));
      tick();

      // Abort after 2 of 8 handshakes, then restart with a new IV.
      iv_in = 128'hB1; num_blocks = 16'd8; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("abort_pre_idx", 128'(out_idx), 128'(2));
      abort = 1'b1; out_ready = 1'b0;
      tick();
      abort = 1'b0;
      chk("abort_valid", 128'(out_valid), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      tick();
      chk("abort_done2", 128'(done), 128'(0));
      iv_in = 128'hC0C0; num_blocks = 16'd2; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_valid", 128'(out_valid), 128'(1));
      chk("restart_idx", 128'(out_idx), 128'(0));
      chk("restart_block", out_block, 128'hC0C0);
      tick(); tick(); tick();

      // Abort and start together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_start_valid", 128'(out_valid), 128'(0));
      chk("abort_start_busy", 128'(busy), 128'(0));

      // Start while busy is ignored.
      iv_in = 128'hD000; num_blocks = 16'd3; out_ready = 1'b1; start = 1'b1;
      tick();
      iv_in = 128'hE000; num_blocks = 16'd9;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("busy_start_block%0d", k), out_block, 128'hD000 + 128'(k));
         tick();
      end
      start = 1'b0;
      chk("busy_start_done", 128'(done), 128'(1));
      tick();
      chk("busy_start_idle", 128'(busy), 128'(0));

      // Asynchronous reset mid-burst, between clock edges.
      iv_in = {96'h5, 32'hFFFFFFFF}; num_blocks = 16'd5; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mid_wrap_set", 128'(wrap), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 128'(out_valid), 128'(0));
      chk("arst_busy", 128'(busy), 128'(0));
      chk("arst_done", 128'(done), 128'(0));
      chk("arst_wrap", 128'(wrap), 128'(0));
      chk("arst_block", out_block, 128'(0));
      chk("arst_idx", 128'(out_idx), 128'(0));
      #1 rst_n = 1'b1;
      iv_in = 128'hF00D; num_blocks = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_rst_valid", 128'(out_valid), 128'(1));
      chk("post_rst_block", out_block, 128'hF00D);
      tick();
      chk("post_rst_done", 128'(done), 128'(1));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
